// File: rtl/fillrect_pkg.sv
// Shared types and default screen geometry for the rectangle fill engine.
package fill_pkg;

    typedef enum logic [1:0] {
        SOLID    = 2'd0,
        STRIPE_X = 2'd1,
        STRIPE_Y = 2'd2,
        RSVD     = 2'd3
    } fill_mode_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        FILL  = 2'd2,
        DONE  = 2'd3
    } fill_state_t;

    localparam int SCREEN_W_DEF = 160;
    localparam int SCREEN_H_DEF = 120;

endpackage

// File: rtl/fillrect_rect_clip.sv
// Combinational corner normalisation and screen clipping for one rectangle.
module rect_clip #(
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120,
    parameter int X_W      = 8,
    parameter int Y_W      = 7
) (
    input  logic [X_W-1:0] x0,
    input  logic [Y_W-1:0] y0,
    input  logic [X_W-1:0] x1,
    input  logic [Y_W-1:0] y1,
    output logic [X_W-1:0] xl,
    output logic [X_W-1:0] xh,
    output logic [Y_W-1:0] yl,
    output logic [Y_W-1:0] yh,
    output logic           empty
);

    localparam logic [X_W-1:0] X_MAX = X_W'(SCREEN_W - 1);
    localparam logic [Y_W-1:0] Y_MAX = Y_W'(SCREEN_H - 1);

    logic [X_W-1:0] hi_x;
    logic [Y_W-1:0] hi_y;

    assign xl   = (x0 < x1) ? x0 : x1;
    assign hi_x = (x0 < x1) ? x1 : x0;
    assign yl   = (y0 < y1) ? y0 : y1;
    assign hi_y = (y0 < y1) ? y1 : y0;

    // Only the far edge is clamped; a near edge past the screen means nothing is visible.
    assign xh    = (hi_x > X_MAX) ? X_MAX : hi_x;
    assign yh    = (hi_y > Y_MAX) ? Y_MAX : hi_y;
    assign empty = (xl > X_MAX) || (yl > Y_MAX);

endmodule

// File: rtl/fillrect.sv
// Rectangle fill engine: paints a clipped, normalised rectangle into the VGA
// adapter one pixel per clock, column-major, in one of three colour modes.
module fillrect
    import fill_pkg::*;
#(
    parameter int SCREEN_W = SCREEN_W_DEF,
    parameter int SCREEN_H = SCREEN_H_DEF,
    parameter int X_W      = 8,
    parameter int Y_W      = 7,
    parameter int COLOUR_W = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [X_W-1:0]      x0,
    input  logic [Y_W-1:0]      y0,
    input  logic [X_W-1:0]      x1,
    input  logic [Y_W-1:0]      y1,
    input  logic [COLOUR_W-1:0] colour,
    input  logic [1:0]          mode,
    output logic                busy,
    output logic                done,
    output logic [X_W-1:0]      vga_x,
    output logic [Y_W-1:0]      vga_y,
    output logic [COLOUR_W-1:0] vga_colour,
    output logic                vga_plot
);

    // Handshake: start is a level held by the controller; it is sampled only in
    // IDLE, done stays high until start is seen low, so a held start never re-fires.

    fill_state_t         state;
    fill_mode_t          mode_r;
    logic [X_W-1:0]      ax, bx, xl, xh, cx;
    logic [Y_W-1:0]      ay, by, yl, yh, cy;
    logic [COLOUR_W-1:0] colour_r;

    logic [X_W-1:0]      c_xl, c_xh;
    logic [Y_W-1:0]      c_yl, c_yh;
    logic                c_empty;
    logic [COLOUR_W-1:0] pix_colour;

    rect_clip #(
        .SCREEN_W (SCREEN_W),
        .SCREEN_H (SCREEN_H),
        .X_W      (X_W),
        .Y_W      (Y_W)
    ) u_clip (
        .x0    (ax),
        .y0    (ay),
        .x1    (bx),
        .y1    (by),
        .xl    (c_xl),
        .xh    (c_xh),
        .yl    (c_yl),
        .yh    (c_yh),
        .empty (c_empty)
    );

    always_comb begin
        pix_colour = colour_r;
        case (mode_r)
            STRIPE_X: pix_colour = COLOUR_W'(cx);
            STRIPE_Y: pix_colour = COLOUR_W'(cy);
            default:  pix_colour = colour_r;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            mode_r     <= SOLID;
            ax         <= '0;
            bx         <= '0;
            ay         <= '0;
            by         <= '0;
            colour_r   <= '0;
            xl         <= '0;
            xh         <= '0;
            yl         <= '0;
            yh         <= '0;
            cx         <= '0;
            cy         <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            vga_x      <= '0;
            vga_y      <= '0;
            vga_colour <= '0;
            vga_plot   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        ax       <= x0;
                        ay       <= y0;
                        bx       <= x1;
                        by       <= y1;
                        colour_r <= colour;
                        mode_r   <= fill_mode_t'(mode);
                        busy     <= 1'b1;
                        state    <= SETUP;
                    end
                end
                SETUP: begin
                    if (c_empty) begin
                        vga_x      <= '0;
                        vga_y      <= '0;
                        vga_colour <= '0;
                        state      <= DONE;
                    end else begin
                        xl    <= c_xl;
                        xh    <= c_xh;
                        yl    <= c_yl;
                        yh    <= c_yh;
                        cx    <= c_xl;
                        cy    <= c_yl;
                        state <= FILL;
                    end
                end
                FILL: begin
                    vga_plot   <= 1'b1;
                    vga_x      <= cx;
                    vga_y      <= cy;
                    vga_colour <= pix_colour;
                    if (cx == xh && cy == yh) begin
                        state <= DONE;
                    end else if (cy < yh) begin
                        cy <= cy + 1'b1;
                    end else begin
                        cy <= yl;
                        cx <= cx + 1'b1;
                    end
                end
                DONE: begin
                    // First DONE cycle retires the last plot; done then waits for start low.
                    vga_plot <= 1'b0;
                    if (!done) begin
                        done <= 1'b1;
                        busy <= 1'b0;
                    end else if (!start) begin
                        done  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fillrect.sv
// Directed self-checking bench for fillrect: geometry, colour modes, clipping,
// latency, async reset and the start/done restart rule.
module tb_fillrect;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] x0, x1;
    logic [6:0] y0, y1;
    logic [2:0] colour;
    logic [1:0] mode;
    logic       busy, done, vga_plot;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;

    int n_checks = 0;
    int n_fail   = 0;

    logic [17:0] exp_q[$];
    logic [17:0] pix_q[$];
    int mism, extra, busy_bad, xbad;

    fillrect dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .x0         (x0),
        .y0         (y0),
        .x1         (x1),
        .y1         (y1),
        .colour     (colour),
        .mode       (mode),
        .busy       (busy),
        .done       (done),
        .vga_x      (vga_x),
        .vga_y      (vga_y),
        .vga_colour (vga_colour),
        .vga_plot   (vga_plot)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [17:0] pk(input int x, input int y, input int c);
        return {8'(x), 7'(y), 3'(c)};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Scoreboard: every plot is compared in order against the expected queue.
    always @(negedge clk) begin
        if (vga_plot) begin
            logic [17:0] p;
            p = {vga_x, vga_y, vga_colour};
            pix_q.push_back(p);
            if (busy !== 1'b1) busy_bad++;
            if (vga_x > 8'd159) xbad++;
            if (exp_q.size() == 0) extra++;
            else if (exp_q.pop_front() !== p) mism++;
        end
    end

    task automatic clear_sb();
        exp_q.delete();
        pix_q.delete();
        mism = 0; extra = 0; busy_bad = 0; xbad = 0;
    endtask

    // Expected scan over already-normalised, already-clipped bounds.
    task automatic build_exp(input int xl, input int xh, input int yl, input int yh,
                             input int md, input int col);
        for (int x = xl; x <= xh; x++)
            for (int y = yl; y <= yh; y++)
                exp_q.push_back(pk(x, y, (md == 1) ? x % 8 : (md == 2) ? y % 8 : col));
    endtask

    task automatic start_fill(input int ax, input int ay, input int bx, input int by,
                              input int col, input int md);
        @(negedge clk);
        x0 = 8'(ax); y0 = 7'(ay); x1 = 8'(bx); y1 = 7'(by);
        colour = 3'(col); mode = 2'(md);
        start = 1'b1;
    endtask

    // k counts negedges after the edge that samples start.
    task automatic wait_done(input int budget, output int cycles, output int first_k,
                             output logic plot_before);
        logic prev;
        prev = 1'b0; cycles = 0; first_k = 0; plot_before = 1'b0;
        for (int k = 1; k <= budget; k++) begin
            @(negedge clk);
            if (vga_plot && first_k == 0) first_k = k;
            if (done) begin
                cycles = k;
                plot_before = prev;
                break;
            end
            prev = vga_plot;
        end
        if (cycles == 0) check("done_timeout", 0, 1);
    endtask

    task automatic release_start(input string tag);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check({tag, "_done_fall"}, done, 0);
        check({tag, "_busy_idle"}, busy, 0);
    endtask

    task automatic check_sb(input string tag, input int n);
        check({tag, "_plots"}, pix_q.size(), n);
        check({tag, "_pix_mism"}, mism, 0);
        check({tag, "_extra"}, extra, 0);
        check({tag, "_busy_bad"}, busy_bad, 0);
    endtask

    int cyc, fk;
    logic pb;

    initial begin
        rst = 1'b0; start = 1'b0;
        x0 = '0; y0 = '0; x1 = '0; y1 = '0; colour = '0; mode = '0;
        clear_sb();
        #1 rst = 1'b1;
        #1;
        check("rst_plot", vga_plot, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_xy", {vga_x, vga_y, vga_colour}, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Full screen, STRIPE_X.
        clear_sb();
        build_exp(0, 159, 0, 119, 1, 0);
        start_fill(0, 0, 159, 119, 0, 1);
        wait_done(20000, cyc, fk, pb);
        check_sb("full", 19200);
        check("full_first", pix_q[0], pk(0, 0, 0));
        check("full_8_5", pix_q[965], pk(8, 5, 0));
        check("full_last", pix_q[19199], pk(159, 119, 7));
        check("full_done_lat", cyc, 19203);
        check("full_done_after_plot", pb, 1);
        release_start("full");

        // Swapped corners, SOLID colour 5, then start held in DONE.
        clear_sb();
        build_exp(10, 12, 20, 21, 0, 5);
        start_fill(12, 21, 10, 20, 5, 0);
        wait_done(100, cyc, fk, pb);
        check_sb("swap", 6);
        check("swap_p0", pix_q[0], pk(10, 20, 5));
        check("swap_p1", pix_q[1], pk(10, 21, 5));
        check("swap_p2", pix_q[2], pk(11, 20, 5));
        check("swap_p5", pix_q[5], pk(12, 21, 5));
        check("swap_first_lat", fk, 3);
        check("swap_done_lat", cyc, 9);
        repeat (100) @(negedge clk);
        check("hold_no_plots", pix_q.size(), 6);
        check("hold_done", done, 1);
        start = 1'b0;
        clear_sb();
        build_exp(10, 12, 20, 21, 0, 5);
        start_fill(12, 21, 10, 20, 5, 0);
        wait_done(100, cyc, fk, pb);
        check_sb("restart", 6);
        check("restart_done_lat", cyc, 9);
        release_start("restart");

        // Clipping, STRIPE_Y.
        clear_sb();
        build_exp(150, 159, 110, 119, 2, 0);
        start_fill(150, 110, 200, 127, 0, 2);
        wait_done(300, cyc, fk, pb);
        check_sb("clip", 100);
        check("clip_first", pix_q[0], pk(150, 110, 6));
        check("clip_last", pix_q[99], pk(159, 119, 7));
        check("clip_xbad", xbad, 0);
        release_start("clip");

        // Single pixel with reserved mode behaving as SOLID.
        clear_sb();
        build_exp(5, 5, 5, 5, 0, 6);
        start_fill(5, 5, 5, 5, 6, 3);
        wait_done(50, cyc, fk, pb);
        check_sb("single", 1);
        check("single_pix", pix_q[0], pk(5, 5, 6));
        release_start("single");

        // Fully off-screen: no plots, done at start edge + 2, outputs zero.
        clear_sb();
        start_fill(170, 0, 180, 5, 4, 0);
        wait_done(50, cyc, fk, pb);
        check("off_plots", pix_q.size(), 0);
        check("off_done_lat", cyc, 3);
        check("off_outputs", {vga_x, vga_y, vga_colour}, 0);
        release_start("off");

        // Asynchronous reset after 50 plots, then a fresh fill with start held.
        clear_sb();
        build_exp(0, 9, 0, 9, 0, 3);
        start_fill(9, 9, 0, 0, 3, 0);
        for (int k = 0; k < 200 && pix_q.size() < 50; k++) @(negedge clk);
        check("mid_reached_50", pix_q.size(), 50);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_plot", vga_plot, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_xy", {vga_x, vga_y}, 0);
        clear_sb();
        build_exp(0, 9, 0, 9, 0, 3);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        wait_done(300, cyc, fk, pb);
        check_sb("after_rst", 100);
        check("after_rst_first", pix_q[0], pk(0, 0, 3));
        check("after_rst_lat", cyc, 103);
        release_start("after_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
